// File: rtl/ysyx_lsu_pkg.sv
// Shared types and constants for the LSU responder: FSM states, access sizes, op bits, AXI responses.
package ysyx_lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW_W,
    B,
    DONE
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int unsigned OP_UNSIGNED_BIT = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_lsu_if.sv
// AXI4-Lite channel bundle between the LSU (master) and the bus crossbar/arbiter (slave).
interface ysyx_lsu_if #(
  parameter int unsigned BIT_W = 32
);
  logic [BIT_W-1:0] araddr;
  logic             arvalid;
  logic             arready;
  logic [BIT_W-1:0] rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;
  logic [BIT_W-1:0] awaddr;
  logic             awvalid;
  logic             awready;
  logic [BIT_W-1:0] wdata;
  logic [3:0]       wstrb;
  logic             wvalid;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_lsu_align.sv
// Byte-lane steering: store strobes/replicated data, load lane extraction with extension, alignment check.
module ysyx_lsu_align
  import ysyx_lsu_pkg::*;
(
  input  logic [1:0]      addr_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ldata_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted    = rdata_i >> {addr_i, 3'b000};
    wstrb_o    = '0;
    wdata_o    = '0;
    ldata_o    = '0;
    misalign_o = 1'b0;
    case (size_i)
      SZ_B: begin
        wstrb_o = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        ldata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        wstrb_o    = 4'b0011 << addr_i;
        wdata_o    = {2{wdata_i[15:0]}};
        ldata_o    = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
        misalign_o = addr_i[0];
      end
      SZ_W: begin
        wstrb_o    = 4'b1111;
        wdata_o    = wdata_i;
        // Aligned words never shift, so the shifted view is the bus word itself.
        ldata_o    = shifted;
        misalign_o = (addr_i != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_lsu_resp.sv
// EXU load/store responder: runs one held request as an AXI4-Lite transaction and pulses completion.
module ysyx_lsu_resp
  import ysyx_lsu_pkg::*;
#(
  parameter int unsigned BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_avalid_i,
  input  logic             exu_ren_i,
  input  logic             exu_wen_i,
  input  logic [BIT_W-1:0] exu_addr_i,
  input  logic [BIT_W-1:0] exu_wdata_i,
  input  logic [3:0]       exu_op_i,
  output logic [BIT_W-1:0] exu_rdata_o,
  output logic             exu_rvalid_o,
  output logic             exu_wready_o,
  output logic             exu_fault_o,
  ysyx_lsu_if.master       m
);

  lsu_state_e       state_q, state_d;
  logic [BIT_W-1:0] addr_q, addr_d;
  logic [BIT_W-1:0] wdata_q, wdata_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic             ren_q, ren_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic [BIT_W-1:0] rdata_q, rdata_d;
  logic             fault_q, fault_d;

  logic             idle;
  logic [1:0]       al_addr;
  logic [1:0]       al_size;
  logic [3:0]       al_wstrb;
  logic [BIT_W-1:0] al_wdata;
  logic [BIT_W-1:0] al_ldata;
  logic             al_misalign;
  logic             illegal;
  logic             aw_hs, w_hs;
  logic             unused_op;

  assign unused_op = exu_op_i[3];

  // Alignment is judged on the live request while idle, then on the captured copy.
  assign idle    = (state_q == IDLE);
  assign al_addr = idle ? exu_addr_i[1:0] : addr_q[1:0];
  assign al_size = idle ? exu_op_i[1:0]   : size_q;

  ysyx_lsu_align u_align (
    .addr_i     (al_addr),
    .size_i     (al_size),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (m.rdata),
    .wstrb_o    (al_wstrb),
    .wdata_o    (al_wdata),
    .ldata_o    (al_ldata),
    .misalign_o (al_misalign)
  );

  assign illegal = al_misalign || (exu_op_i[1:0] == 2'd3) || (exu_ren_i == exu_wen_i);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    ren_d     = ren_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exu_avalid_i) begin
          addr_d    = exu_addr_i;
          wdata_d   = exu_wdata_i;
          size_d    = exu_op_i[1:0];
          uns_d     = exu_op_i[OP_UNSIGNED_BIT];
          ren_d     = exu_ren_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (illegal) begin
            fault_d = 1'b1;
            state_d = DONE;
            if (exu_ren_i) rdata_d = '0;
          end else begin
            fault_d = 1'b0;
            state_d = exu_ren_i ? AR : AW_W;
          end
        end
      end
      AR: if (m.arready) state_d = R;
      R: begin
        if (m.rvalid) begin
          fault_d = (m.rresp != RESP_OKAY);
          rdata_d = (m.rresp != RESP_OKAY) ? '0 : al_ldata;
          state_d = DONE;
        end
      end
      AW_W: begin
        aw_hs     = !aw_done_q && m.awready;
        w_hs      = !w_done_q && m.wready;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = B;
      end
      B: begin
        if (m.bvalid) begin
          fault_d = (m.bresp != RESP_OKAY);
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      ren_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      ren_q     <= ren_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
    end
  end

  assign m.araddr  = {addr_q[BIT_W-1:2], 2'b00};
  assign m.arvalid = (state_q == AR);
  assign m.rready  = (state_q == R);
  assign m.awaddr  = {addr_q[BIT_W-1:2], 2'b00};
  assign m.awvalid = (state_q == AW_W) && !aw_done_q;
  assign m.wdata   = al_wdata;
  assign m.wstrb   = al_wstrb;
  assign m.wvalid  = (state_q == AW_W) && !w_done_q;
  assign m.bready  = (state_q == B);

  assign exu_rdata_o  = rdata_q;
  assign exu_rvalid_o = (state_q == DONE) && ren_q;
  assign exu_wready_o = (state_q == DONE) && !ren_q;
  assign exu_fault_o  = (state_q == DONE) && fault_q;

endmodule

// File: tb/tb_ysyx_lsu_resp.sv
// Directed bench for ysyx_lsu_resp: byte-level reference model, AXI4-Lite slave responder, per-cycle compare.
module tb_ysyx_lsu_resp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        avalid, ren, wen;
  logic [31:0] addr, wdata;
  logic [3:0]  op;
  logic [31:0] rdata_o;
  logic        rvalid_o, wready_o, fault_o;

  ysyx_lsu_if #(.BIT_W(32)) bus ();

  ysyx_lsu_resp #(.BIT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .exu_avalid_i (avalid),
    .exu_ren_i    (ren),
    .exu_wen_i    (wen),
    .exu_addr_i   (addr),
    .exu_wdata_i  (wdata),
    .exu_op_i     (op),
    .exu_rdata_o  (rdata_o),
    .exu_rvalid_o (rvalid_o),
    .exu_wready_o (wready_o),
    .exu_fault_o  (fault_o),
    .m            (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expectation for the transaction in flight
  logic        pend = 1'b0, pend_load = 1'b0, pend_fault = 1'b0, pend_rd = 1'b0, pend_wr = 1'b0;
  logic [31:0] pend_rdata = '0, model_rdata = '0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
  logic [3:0]  seen_wstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic bad);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: observed 1, required 0", name);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    longint unsigned v, mask;
    int bits;
    bits = 8 << size;
    v    = longint'(word) >> (8 * int'(off));
    mask = (64'd1 << bits) - 64'd1;
    v    = v & mask;
    if (!uns && (((v >> (bits - 1)) & 64'd1) != 0)) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] size);
    longint unsigned r, mask;
    int bits;
    bits = 8 << size;
    mask = (64'd1 << bits) - 64'd1;
    r    = 0;
    for (int i = 0; i < 32; i += bits) r |= (longint'(wd) & mask) << i;
    return r[31:0];
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [1:0] off, input logic [1:0] size);
    int s;
    s = ((1 << (1 << size)) - 1) << off;
    return s[3:0];
  endfunction

  // Per-cycle comparison against the expectation; sampled mid-low-phase, clear of edges and drives.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (rvalid_o || wready_o) begin
        flag("unexpected_done", !pend);
        chk("rvalid", {31'b0, rvalid_o}, {31'b0, pend_load});
        chk("wready", {31'b0, wready_o}, {31'b0, !pend_load});
        chk("fault", {31'b0, fault_o}, {31'b0, pend_fault});
        chk("rdata_done", rdata_o, pend_rdata);
        model_rdata = pend_rdata;
        pend = 1'b0;
      end else begin
        flag("fault_without_done", fault_o);
        chk("rdata_hold", rdata_o, model_rdata);
      end
      if (bus.arvalid) flag("arvalid_unexpected", !(pend && pend_rd && ar_cnt == 0));
      if (bus.awvalid) flag("awvalid_unexpected", !(pend && pend_wr && aw_cnt == 0));
      if (bus.wvalid)  flag("wvalid_unexpected",  !(pend && pend_wr && w_cnt == 0));
      if (bus.arvalid && bus.arready) ar_cnt++;
      if (bus.awvalid && bus.awready) aw_cnt++;
      if (bus.wvalid && bus.wready)   w_cnt++;
    end
  end

  task automatic wait_sig(input string name, ref logic s, output logic ok);
    int n = 0;
    while (!s && n < 50) begin @(negedge clk); n++; end
    ok = s;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got 0, expected 1 within 50 cycles", name);
    end
  endtask

  task automatic svc_ar(input int dly, input logic [31:0] exp_a);
    logic ok;
    wait_sig("arvalid", bus.arvalid, ok);
    if (ok) begin
      repeat (dly) @(negedge clk);
      bus.arready = 1'b1;
      seen_araddr = bus.araddr;
      chk("araddr", bus.araddr, exp_a);
      @(negedge clk);
      bus.arready = 1'b0;
    end
  endtask

  task automatic svc_r(input int dly, input logic [31:0] word, input logic [1:0] resp);
    logic ok;
    wait_sig("rready", bus.rready, ok);
    if (ok) begin
      repeat (dly) @(negedge clk);
      bus.rvalid = 1'b1; bus.rdata = word; bus.rresp = resp;
      @(negedge clk);
      bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    end
  endtask

  task automatic svc_aw(input int dly, input logic [31:0] exp_a);
    logic ok;
    wait_sig("awvalid", bus.awvalid, ok);
    if (ok) begin
      repeat (dly) @(negedge clk);
      bus.awready = 1'b1;
      seen_awaddr = bus.awaddr;
      chk("awaddr", bus.awaddr, exp_a);
      @(negedge clk);
      bus.awready = 1'b0;
    end
  endtask

  task automatic svc_w(input int dly, input logic [31:0] exp_d, input logic [3:0] exp_s);
    logic ok;
    wait_sig("wvalid", bus.wvalid, ok);
    if (ok) begin
      repeat (dly) @(negedge clk);
      bus.wready = 1'b1;
      seen_wdata = bus.wdata;
      seen_wstrb = bus.wstrb;
      chk("wdata", bus.wdata, exp_d);
      chk("wstrb", {28'b0, bus.wstrb}, {28'b0, exp_s});
      @(negedge clk);
      bus.wready = 1'b0;
    end
  endtask

  task automatic svc_b(input int dly, input logic [1:0] resp);
    logic ok;
    wait_sig("bready", bus.bready, ok);
    if (ok) begin
      repeat (dly) @(negedge clk);
      bus.bvalid = 1'b1; bus.bresp = resp;
      @(negedge clk);
      bus.bvalid = 1'b0; bus.bresp = 2'b00;
    end
  endtask

  task automatic run_txn(input string tag, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] o, input logic [31:0] word,
                         input logic [1:0] resp, input int ar_d, input int r_d, input int aw_d,
                         input int w_d, input int b_d, input int exp_lat);
    logic [1:0]  sz;
    logic        illegal, done;
    logic [31:0] abase;
    int          n;
    sz      = o[1:0];
    abase   = {a[31:2], 2'b00};
    illegal = (r == w) || (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    @(negedge clk);
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    pend_load  = r;
    pend_rd    = r && !illegal;
    pend_wr    = w && !illegal;
    pend_fault = illegal || (resp != 2'b00);
    pend_rdata = !r ? model_rdata : (pend_fault ? 32'h0 : model_load(word, a[1:0], sz, o[2]));
    pend       = 1'b1;
    avalid = 1'b1; ren = r; wen = w; addr = a; wdata = wd; op = o;
    fork
      begin if (pend_rd) svc_ar(ar_d, abase); end
      begin if (pend_rd) svc_r(r_d, word, resp); end
      begin if (pend_wr) svc_aw(aw_d, abase); end
      begin if (pend_wr) svc_w(w_d, model_wdata(wd, sz), model_wstrb(a[1:0], sz)); end
      begin if (pend_wr) svc_b(b_d, resp); end
      begin
        n = 0; done = 1'b0;
        while (!done && n < 100) begin
          @(posedge clk); #1;
          n++;
          if (rvalid_o || wready_o) done = 1'b1;
        end
        avalid = 1'b0; ren = 1'b0; wen = 1'b0;
        if (!done) begin
          checks++; errors++;
          $display("FAIL %s_completion_timeout: no rvalid/wready within 100 cycles", tag);
        end else if (exp_lat != 0) begin
          chk({tag, "_latency"}, n + 1, exp_lat);
        end
      end
    join
    @(negedge clk);
    chk({tag, "_ar_count"}, ar_cnt, {31'b0, pend_rd});
    chk({tag, "_aw_count"}, aw_cnt, {31'b0, pend_wr});
    chk({tag, "_w_count"},  w_cnt,  {31'b0, pend_wr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   n;
    rst = 1'b1; avalid = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; op = '0;
    bus.arready = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bresp = 2'b00; bus.bvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_arvalid", {31'b0, bus.arvalid}, 32'd0);
    chk("reset_awvalid", {31'b0, bus.awvalid}, 32'd0);
    chk("reset_wvalid",  {31'b0, bus.wvalid},  32'd0);
    chk("reset_rready",  {31'b0, bus.rready},  32'd0);
    chk("reset_bready",  {31'b0, bus.bready},  32'd0);
    chk("reset_rvalid",  {31'b0, rvalid_o},    32'd0);
    chk("reset_wready",  {31'b0, wready_o},    32'd0);
    chk("reset_fault",   {31'b0, fault_o},     32'd0);
    chk("reset_rdata",   rdata_o,              32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_rdata = '0;

    //       tag     r     w     addr          wdata         op     bus word      resp  ar r aw w b lat
    run_txn("lw",   1'b1, 1'b0, 32'h8000_0004, 32'h0,        4'h2, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 4);
    chk("lw_araddr_lit", seen_araddr, 32'h8000_0004);
    chk("lw_rdata_lit",  rdata_o,     32'hDEAD_BEEF);
    run_txn("lb",   1'b1, 1'b0, 32'h8000_0003, 32'h0,        4'h0, 32'h80FF_FFFF, 2'b00, 0, 0, 0, 0, 0, 4);
    chk("lb_rdata_lit",  rdata_o,     32'hFFFF_FF80);
    run_txn("lbu",  1'b1, 1'b0, 32'h8000_0003, 32'h0,        4'h4, 32'h80FF_FFFF, 2'b00, 0, 0, 0, 0, 0, 4);
    chk("lbu_rdata_lit", rdata_o,     32'h0000_0080);
    run_txn("lhu",  1'b1, 1'b0, 32'h8000_0002, 32'h0,        4'h5, 32'h80FF_FFFF, 2'b00, 0, 0, 0, 0, 0, 4);
    chk("lhu_rdata_lit", rdata_o,     32'h0000_80FF);
    run_txn("lh",   1'b1, 1'b0, 32'h8000_0002, 32'h0,        4'h1, 32'h80FF_FFFF, 2'b00, 0, 0, 0, 0, 0, 4);
    run_txn("sh",   1'b0, 1'b1, 32'h8000_0002, 32'h1234_ABCD, 4'h1, 32'h0,        2'b00, 0, 0, 0, 0, 0, 4);
    chk("sh_awaddr_lit", seen_awaddr, 32'h8000_0000);
    chk("sh_wstrb_lit",  {28'b0, seen_wstrb}, 32'h0000_000C);
    chk("sh_wdata_lit",  seen_wdata,  32'hABCD_ABCD);
    run_txn("sb",   1'b0, 1'b1, 32'h8000_0001, 32'h0000_00A5, 4'h0, 32'h0,        2'b00, 0, 0, 0, 0, 0, 4);
    chk("sb_wstrb_lit",  {28'b0, seen_wstrb}, 32'h0000_0002);
    chk("sb_wdata_lit",  seen_wdata,  32'hA5A5_A5A5);
    run_txn("sw_w_first", 1'b0, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 4'h2, 32'h0, 2'b00, 0, 0, 3, 0, 2, 0);
    run_txn("lw_misalign", 1'b1, 1'b0, 32'h8000_0002, 32'h0, 4'h2, 32'h1111_1111, 2'b00, 0, 0, 0, 0, 0, 2);
    chk("lw_misalign_rdata_lit", rdata_o, 32'h0);
    run_txn("sw_berr", 1'b0, 1'b1, 32'h8000_000C, 32'h5555_AAAA, 4'h2, 32'h0, 2'b10, 0, 0, 0, 0, 0, 4);
    run_txn("lw_rerr", 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h2, 32'h7777_7777, 2'b11, 0, 0, 0, 0, 0, 4);
    run_txn("lb_slow", 1'b1, 1'b0, 32'h8000_0001, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 2, 1, 0, 0, 0, 0);
    run_txn("neither", 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h2, 32'h0, 2'b00, 0, 0, 0, 0, 0, 2);
    run_txn("size3",   1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h3, 32'h0, 2'b00, 0, 0, 0, 0, 0, 2);
    run_txn("lw_op3",  1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'hA, 32'h7FFF_0001, 2'b00, 0, 0, 0, 0, 0, 4);
    run_txn("sh_odd",  1'b0, 1'b1, 32'h8000_0003, 32'hFFFF_FFFF, 4'h1, 32'h0, 2'b00, 0, 0, 0, 0, 0, 2);

    // Reset while a read response is being presented
    @(negedge clk);
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    pend_load = 1'b1; pend_rd = 1'b1; pend_wr = 1'b0; pend_fault = 1'b0; pend_rdata = 32'h0; pend = 1'b1;
    avalid = 1'b1; ren = 1'b1; wen = 1'b0; addr = 32'h8000_0010; op = 4'h2;
    svc_ar(0, 32'h8000_0010);
    wait_sig("rready", bus.rready, ok);
    bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rready",  {31'b0, bus.rready}, 32'd0);
    chk("rst_arvalid", {31'b0, bus.arvalid}, 32'd0);
    chk("rst_rvalid",  {31'b0, rvalid_o}, 32'd0);
    chk("rst_fault",   {31'b0, fault_o}, 32'd0);
    chk("rst_rdata",   rdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    avalid = 1'b0; ren = 1'b0;
    pend = 1'b0; model_rdata = 32'h0;
    n = 0;
    repeat (5) begin @(posedge clk); #1; if (rvalid_o || wready_o) n++; end
    chk("rst_no_pulse", n, 0);
    run_txn("lw_after_rst", 1'b1, 1'b0, 32'h8000_0014, 32'h0, 4'h2, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 0, 0, 4);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
